// File: rtl/checkerboard_pkg.sv
// Shared definitions for the checkerboard move controller and board RAM:
// board geometry, cell encoding and the controller FSM state type.
package checkerboard_pkg;

   localparam int ADDR_W = 6;
   localparam int CELLS  = 1 << ADDR_W;
   localparam int CNT_W  = 7;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_BLACK = 2'b01;
   localparam logic [1:0] CELL_WHITE = 2'b10;
   localparam logic [1:0] CELL_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WRITE,
      ST_DONE,
      ST_CLEAR
   } state_e;

endpackage

// File: rtl/checkerboard_state_ram.sv
// Board state memory: one cell per square, 2-bit state, two asynchronous
// read ports and one synchronous write port. Contents are not reset.
module checkerboard_state_ram
   import checkerboard_pkg::*;
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr_1,
   output logic [1:0]        rd_data_out_1,
   input  logic [ADDR_W-1:0] rd_addr_2,
   output logic [1:0]        rd_data_out_2
);

   logic [1:0] mem_q [CELLS];

   // Commit one cell per enabled clock edge
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data_out_1 = mem_q[rd_addr_1];
   assign rd_data_out_2 = mem_q[rd_addr_2];

endmodule

// File: rtl/checkerboard_move_ctrl.sv
// Move/clear sequencer in front of the board RAM. Places a stone only on an
// EMPTY cell with a legal colour, walks the whole board on a clear request,
// and tracks how many black and white stones are on the board.
module checkerboard_move_ctrl
   import checkerboard_pkg::*;
#(
   parameter int ADDR_W = checkerboard_pkg::ADDR_W,
   parameter int CELLS  = 2 ** ADDR_W,
   parameter int CNT_W  = checkerboard_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic              mv_valid,
   output logic              mv_ready,
   input  logic [ADDR_W-1:0] mv_addr,
   input  logic [1:0]        mv_color,
   output logic              mv_done,
   output logic              mv_ok,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [1:0]        ram_wr_data,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [1:0]        ram_rd_data,
   output logic [CNT_W-1:0]  black_count,
   output logic [CNT_W-1:0]  white_count
);

   // The walk index is one bit wider than an address so the last cell is
   // detected by value and the index never wraps inside one walk.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(CELLS - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        color_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W:0]   idx_q;
   logic              clear_pending_q;
   logic              ok_q;
   logic [CNT_W-1:0]  black_q;
   logic [CNT_W-1:0]  white_q;

   // Sequencer: move handshake, occupancy check, stone write and board clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         color_q         <= CELL_EMPTY;
         rd_addr_q       <= '0;
         idx_q           <= '0;
         clear_pending_q <= 1'b0;
         ok_q            <= 1'b0;
         black_q         <= '0;
         white_q         <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Clear has priority over a move presented in the same cycle
               if (clear_req || clear_pending_q) begin
                  state_q <= ST_CLEAR;
                  idx_q   <= '0;
               end else if (mv_valid) begin
                  state_q   <= ST_CHECK;
                  addr_q    <= mv_addr;
                  color_q   <= mv_color;
                  rd_addr_q <= mv_addr;
               end
            end
            ST_CHECK: begin
               if (clear_req) clear_pending_q <= 1'b1;
               if (ram_rd_data == CELL_EMPTY &&
                   (color_q == CELL_BLACK || color_q == CELL_WHITE)) begin
                  state_q <= ST_WRITE;
               end else begin
                  ok_q    <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_WRITE: begin
               if (clear_req) clear_pending_q <= 1'b1;
               if (color_q == CELL_BLACK) black_q <= black_q + CNT_W'(1);
               else                       white_q <= white_q + CNT_W'(1);
               ok_q    <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               // A request arriving in DONE is served immediately after it
               if (clear_pending_q || clear_req) begin
                  clear_pending_q <= 1'b1;
                  state_q         <= ST_CLEAR;
                  idx_q           <= '0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               if (idx_q == LAST_IDX) begin
                  black_q         <= '0;
                  white_q         <= '0;
                  clear_pending_q <= 1'b0;
                  state_q         <= ST_IDLE;
               end else begin
                  idx_q <= idx_q + (ADDR_W+1)'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mv_ready    = (state_q == ST_IDLE) && !clear_pending_q && !clear_req;
   assign mv_done     = (state_q == ST_DONE);
   assign mv_ok       = ok_q;
   assign clear_busy  = (state_q == ST_CLEAR);
   assign ram_wr_en   = (state_q == ST_WRITE) || (state_q == ST_CLEAR);
   assign ram_wr_addr = (state_q == ST_CLEAR) ? idx_q[ADDR_W-1:0] : addr_q;
   assign ram_wr_data = (state_q == ST_CLEAR) ? CELL_EMPTY : color_q;
   assign ram_rd_addr = rd_addr_q;
   assign black_count = black_q;
   assign white_count = white_q;

endmodule

// File: tb/tb_checkerboard_move_ctrl.sv
// Bench for checkerboard_move_ctrl attached to checkerboard_state_ram.
// Move results are predicted at acceptance and queued; a monitor pops and
// checks them whenever mv_done is presented.
module tb_checkerboard_move_ctrl;
   import checkerboard_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear_req;
   logic              clear_busy;
   logic              mv_valid;
   logic              mv_ready;
   logic [ADDR_W-1:0] mv_addr;
   logic [1:0]        mv_color;
   logic              mv_done;
   logic              mv_ok;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [1:0]        ram_wr_data;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [1:0]        ram_rd_data;
   logic [CNT_W-1:0]  black_count;
   logic [CNT_W-1:0]  white_count;
   logic [ADDR_W-1:0] rd_addr2;
   logic [1:0]        rd_data2;

   typedef struct {
      logic ok;
      int   cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   wr_cnt = 0;

   always #5 clk = ~clk;

   checkerboard_move_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .mv_valid   (mv_valid),
      .mv_ready   (mv_ready),
      .mv_addr    (mv_addr),
      .mv_color   (mv_color),
      .mv_done    (mv_done),
      .mv_ok      (mv_ok),
      .ram_wr_en  (ram_wr_en),
      .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data),
      .black_count(black_count),
      .white_count(white_count)
   );

   checkerboard_state_ram ram (
      .clk          (clk),
      .wr_en        (ram_wr_en),
      .wr_addr      (ram_wr_addr),
      .wr_data      (ram_wr_data),
      .rd_addr_1    (ram_rd_addr),
      .rd_data_out_1(ram_rd_data),
      .rd_addr_2    (rd_addr2),
      .rd_data_out_2(rd_data2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Cycle counter and count of committed RAM writes
   initial forever begin
      @(posedge clk);
      cyc++;
      if (ram_wr_en) wr_cnt++;
   end

   // Monitor: compare each completion against the oldest prediction
   initial forever begin
      @(negedge clk);
      if (rst_n && mv_done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mv_done_unexpected actual=done(ok=%0b) expected=no_done at cyc %0d", mv_ok, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("mv_ok", {31'b0, mv_ok}, {31'b0, mon_e.ok});
            chk("mv_done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic ram_rd(input logic [ADDR_W-1:0] a, output logic [1:0] d);
      rd_addr2 = a;
      #1;
      d = rd_data2;
   endtask

   task automatic wait_sb(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(nm, sb.size(), 0);
      sb.delete();
      @(negedge clk);
   endtask

   // Issue one move, predict its result, then scramble the inputs
   task automatic do_move(input logic [ADDR_W-1:0] a, input logic [1:0] c, input logic exp_ok);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      mv_valid = 1'b1;
      mv_addr  = a;
      mv_color = c;
      #1;
      while (!mv_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!mv_ready) begin
         chk("accept_timeout", 0, 1);
         mv_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.ok  = exp_ok;
      e.cyc = cyc + (exp_ok ? 2 : 1);
      sb.push_back(e);
      mv_valid = 1'b0;
      mv_addr  = ~a;
      mv_color = CELL_RSVD;
      wait_sb("move_done_timeout");
   endtask

   task automatic run_clear(input string nm);
      int   busy = 0;
      int   n    = 0;
      logic order_ok = 1'b1;
      @(negedge clk);
      clear_req = 1'b1;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      @(negedge clk);
      while (clear_busy && n < 200) begin
         if (!ram_wr_en || ram_wr_addr != busy[ADDR_W-1:0] || ram_wr_data != CELL_EMPTY)
            order_ok = 1'b0;
         busy++;
         n++;
         @(negedge clk);
      end
      chk({nm, "_busy_cycles"}, busy, 64);
      chk({nm, "_walk_order"}, {31'b0, order_ok}, 1);
   endtask

   initial begin
      logic [1:0] d;
      int         p[64];
      int         n, busy, w0, j, t;
      exp_t       e;

      rst_n     = 1'b0;
      clear_req = 1'b0;
      mv_valid  = 1'b0;
      mv_addr   = '0;
      mv_color  = CELL_EMPTY;
      rd_addr2  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_clear_busy", {31'b0, clear_busy}, 0);
      chk("rst_done_ok", {30'b0, mv_done, mv_ok}, 0);
      chk("rst_wr_en", {31'b0, ram_wr_en}, 0);
      chk("rst_addrs", {20'b0, ram_wr_addr, ram_rd_addr}, 0);
      chk("rst_counts", {18'b0, black_count, white_count}, 0);
      rst_n = 1'b1;

      // Initial board clear
      run_clear("clear0");
      chk("clear0_counts", {18'b0, black_count, white_count}, 0);
      chk("clear0_ready", {31'b0, mv_ready}, 1);

      // Legal placement on an empty cell
      do_move(6'h12, CELL_BLACK, 1'b1);
      ram_rd(6'h12, d);
      chk("ram12_black", {30'b0, d}, 32'h1);
      chk("black_after_move", {25'b0, black_count}, 1);

      // Occupied cell is rejected without a write
      w0 = wr_cnt;
      do_move(6'h12, CELL_WHITE, 1'b0);
      chk("occupied_no_write", wr_cnt - w0, 0);
      ram_rd(6'h12, d);
      chk("ram12_kept", {30'b0, d}, 32'h1);
      chk("white_after_reject", {25'b0, white_count}, 0);

      // Reserved colour is rejected without a write
      w0 = wr_cnt;
      do_move(6'h05, CELL_RSVD, 1'b0);
      chk("rsvd_no_write", wr_cnt - w0, 0);
      ram_rd(6'h05, d);
      chk("ram05_empty", {30'b0, d}, 0);

      // Clear and move together in IDLE: clear runs first
      w0 = wr_cnt;
      @(negedge clk);
      clear_req = 1'b1;
      mv_valid  = 1'b1;
      mv_addr   = 6'h07;
      mv_color  = CELL_BLACK;
      #1;
      chk("ready_low_with_clear", {31'b0, mv_ready}, 0);
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      n    = 0;
      busy = 0;
      @(negedge clk);
      #1;
      while (!mv_ready && n < 200) begin
         if (clear_busy) busy++;
         @(negedge clk);
         #1;
         n++;
      end
      chk("simul_clear_cycles", busy, 64);
      @(posedge clk);
      #1;
      e.ok  = 1'b1;
      e.cyc = cyc + 2;
      sb.push_back(e);
      mv_valid = 1'b0;
      wait_sb("simul_move_timeout");
      chk("simul_writes", wr_cnt - w0, 65);
      chk("simul_black", {25'b0, black_count}, 1);

      // Clear requested during CHECK: move finishes, clear follows DONE
      @(negedge clk);
      mv_valid = 1'b1;
      mv_addr  = 6'h20;
      mv_color = CELL_WHITE;
      @(posedge clk);
      #1;
      e.ok  = 1'b1;
      e.cyc = cyc + 2;
      sb.push_back(e);
      mv_valid  = 1'b0;
      clear_req = 1'b1;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      n = 0;
      @(negedge clk);
      while (!mv_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pend_white_at_done", {25'b0, white_count}, 1);
      @(negedge clk);
      chk("pend_clear_after_done", {31'b0, clear_busy}, 1);
      busy = 0;
      n    = 0;
      while (clear_busy && n < 200) begin
         busy++;
         n++;
         @(negedge clk);
      end
      chk("pend_clear_cycles", busy, 64);
      chk("pend_counts", {18'b0, black_count, white_count}, 0);
      chk("pend_sb_drained", sb.size(), 0);

      // Fill the whole board in shuffled order, alternating colours
      for (int i = 0; i < 64; i++) p[i] = i;
      for (int i = 63; i > 0; i--) begin
         j    = $urandom_range(i, 0);
         t    = p[i];
         p[i] = p[j];
         p[j] = t;
      end
      for (int i = 0; i < 64; i++)
         do_move(p[i][ADDR_W-1:0], (i % 2 == 0) ? CELL_BLACK : CELL_WHITE, 1'b1);
      chk("full_black", {25'b0, black_count}, 32);
      chk("full_white", {25'b0, white_count}, 32);
      do_move(p[1][ADDR_W-1:0], CELL_BLACK, 1'b0);
      ram_rd(p[1][ADDR_W-1:0], d);
      chk("full_cell_kept", {30'b0, d}, 32'h2);

      // Reset in the middle of a clear walk
      @(negedge clk);
      clear_req = 1'b1;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
      n = 0;
      @(negedge clk);
      while (!(clear_busy && ram_wr_addr == 6'd20) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reached_idx20", {31'b0, clear_busy && ram_wr_addr == 6'd20}, 1);
      rst_n = 1'b0;
      w0    = wr_cnt;
      @(negedge clk);
      chk("rstmid_busy", {31'b0, clear_busy}, 0);
      chk("rstmid_wr_en", {31'b0, ram_wr_en}, 0);
      chk("rstmid_counts", {18'b0, black_count, white_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstmid_writes", wr_cnt - w0, 1);
      ram_rd(6'd19, d);
      chk("rstmid_ram19", {30'b0, d}, 0);
      ram_rd(6'd20, d);
      chk("rstmid_ram20", {30'b0, d}, 0);
      ram_rd(6'd21, d);
      chk("rstmid_ram21_kept", {31'b0, d != CELL_EMPTY}, 1);
      chk("final_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
